// File: rtl/mt_regfile_pkg.sv
// Shared types and default sizing for the multi-threaded register file.
package mt_regfile_pkg;

  localparam int unsigned DefDWidth     = 64;
  localparam int unsigned DefNumThreads = 4;
  localparam int unsigned DefNumRegs    = 32;

  typedef enum logic {
    ClrIdle,
    ClrClear
  } clr_state_e;

endpackage

// File: rtl/rf_bank.sv
// One thread's register bank: NUM_REGS x D_WIDTH storage, one write port and
// two registered read ports. Storage itself is not reset.
module rf_bank
  import mt_regfile_pkg::*;
#(
  parameter int unsigned  D_WIDTH  = DefDWidth,
  parameter int unsigned  NUM_REGS = DefNumRegs,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [AW-1:0]      raddr1,
  input  logic [AW-1:0]      raddr2,
  output logic [D_WIDTH-1:0] rdata1,
  output logic [D_WIDTH-1:0] rdata2
);

  logic [D_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see pre-write contents on a same-edge write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata1 <= mem[raddr1];
      rdata2 <= mem[raddr2];
    end
  end

endmodule

// File: rtl/mt_regfile.sv
// Multi-threaded register file with per-bank background clear.
// Define MT_REGFILE_BYPASS_EN to forward same-cycle writeback data to matching reads.
module mt_regfile
  import mt_regfile_pkg::*;
#(
  parameter int unsigned  D_WIDTH     = DefDWidth,
  parameter int unsigned  NUM_THREADS = DefNumThreads,
  parameter int unsigned  NUM_REGS    = DefNumRegs,
  localparam int unsigned AW          = $clog2(NUM_REGS),
  localparam int unsigned TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [TW-1:0]      tid_ID,
  input  logic [AW-1:0]      rs1_ID,
  input  logic [AW-1:0]      rs2_ID,
  output logic [D_WIDTH-1:0] reg1data,
  output logic [D_WIDTH-1:0] reg2data,
  input  logic               wr_en_WB,
  input  logic [TW-1:0]      tid_WB,
  input  logic [AW-1:0]      reg_wraddr,
  input  logic [D_WIDTH-1:0] data_WB,
  input  logic               clr_req,
  input  logic [TW-1:0]      clr_tid,
  output logic               clr_busy,
  output logic               clr_done
);

  localparam logic [AW-1:0] IdxFirst = AW'(1);
  localparam logic [AW-1:0] IdxLast  = AW'(NUM_REGS - 1);

  clr_state_e         state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [TW-1:0]      clr_tid_q, clr_tid_d;
  logic               clr_done_q, clr_done_d;

  logic               clearing;
  logic               rd_tid_ok, wb_tid_ok, clr_tid_ok;
  logic               wb_ok, rd_blank;
  logic               zero1_q, zero2_q;
  logic [TW-1:0]      sel_q;
  logic [D_WIDTH-1:0] rd1_pre, rd2_pre;
  logic [D_WIDTH-1:0] bank_rd1 [NUM_THREADS];
  logic [D_WIDTH-1:0] bank_rd2 [NUM_THREADS];

  assign clearing   = (state_q == ClrClear);
  assign rd_tid_ok  = 32'(tid_ID) < NUM_THREADS;
  assign wb_tid_ok  = 32'(tid_WB) < NUM_THREADS;
  assign clr_tid_ok = 32'(clr_tid) < NUM_THREADS;

  // Writeback into the bank under clear is dropped so the clear wins.
  assign wb_ok    = wr_en_WB && wb_tid_ok && (reg_wraddr != '0) &&
                    !(clearing && (tid_WB == clr_tid_q));
  assign rd_blank = !rd_tid_ok || (clearing && (tid_ID == clr_tid_q));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_tid_d  = clr_tid_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      ClrIdle: begin
        if (clr_req && clr_tid_ok) begin
          state_d   = ClrClear;
          idx_d     = IdxFirst;
          clr_tid_d = clr_tid;
        end
      end
      ClrClear: begin
        if (idx_q == IdxLast) begin
          state_d    = ClrIdle;
          idx_d      = IdxFirst;
          clr_done_d = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = ClrIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ClrIdle;
      idx_q      <= IdxFirst;
      clr_tid_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_tid_q  <= clr_tid_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign clr_busy = clearing;
  assign clr_done = clr_done_q;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_bank
    localparam logic [TW-1:0] BankId = TW'(g);
    logic clr_hit;
    logic wb_hit;

    assign clr_hit = clearing && (clr_tid_q == BankId);
    assign wb_hit  = wb_ok && (tid_WB == BankId);

    rf_bank #(
      .D_WIDTH  (D_WIDTH),
      .NUM_REGS (NUM_REGS)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (clr_hit || wb_hit),
      .waddr   (clr_hit ? idx_q : reg_wraddr),
      .wdata   (clr_hit ? '0 : data_WB),
      .raddr1  (rs1_ID),
      .raddr2  (rs2_ID),
      .rdata1  (bank_rd1[g]),
      .rdata2  (bank_rd2[g])
    );
  end

  // Zero flags reset high so both outputs read zero while reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero1_q <= 1'b1;
      zero2_q <= 1'b1;
      sel_q   <= '0;
    end else begin
      zero1_q <= rd_blank || (rs1_ID == '0);
      zero2_q <= rd_blank || (rs2_ID == '0);
      sel_q   <= rd_tid_ok ? tid_ID : '0;
    end
  end

`ifdef MT_REGFILE_BYPASS_EN
  logic               byp1_q, byp2_q;
  logic [D_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp1_q     <= wb_ok && (tid_WB == tid_ID) && (reg_wraddr == rs1_ID);
      byp2_q     <= wb_ok && (tid_WB == tid_ID) && (reg_wraddr == rs2_ID);
      byp_data_q <= data_WB;
    end
  end

  assign rd1_pre = byp1_q ? byp_data_q : bank_rd1[sel_q];
  assign rd2_pre = byp2_q ? byp_data_q : bank_rd2[sel_q];
`else
  assign rd1_pre = bank_rd1[sel_q];
  assign rd2_pre = bank_rd2[sel_q];
`endif

  assign reg1data = zero1_q ? '0 : rd1_pre;
  assign reg2data = zero2_q ? '0 : rd2_pre;

endmodule
